// File: rtl/sales_ledger_if.sv
// rtl/sales_ledger_if.sv - sale event handshake, clear control and statistics bus for the sales ledger
interface sales_ledger_if;
  logic       sale_valid;
  logic [2:0] sale_item;
  logic [1:0] sale_qty;
  logic [6:0] sale_amount;
  logic       sale_ready;
  logic       sale_done;
  logic       sale_err;
  logic       clr_req;
  logic       clr_busy;
  logic       sat_flag;
  logic [4:0] sell1;
  logic [4:0] sell2;
  logic [4:0] sell3;
  logic [4:0] sell4;
  logic [4:0] sell5;
  logic [4:0] sell6;
  logic [4:0] sell7;
  logic [6:0] turnover;

  modport master (
    output sale_valid, sale_item, sale_qty, sale_amount, clr_req,
    input  sale_ready, sale_done, sale_err, clr_busy, sat_flag,
    input  sell1, sell2, sell3, sell4, sell5, sell6, sell7, turnover
  );

  modport slave (
    input  sale_valid, sale_item, sale_qty, sale_amount, clr_req,
    output sale_ready, sale_done, sale_err, clr_busy, sat_flag,
    output sell1, sell2, sell3, sell4, sell5, sell6, sell7, turnover
  );
endinterface

// File: rtl/sales_ledger.sv
// rtl/sales_ledger.sv - per-item saturating sales counters and bounded turnover with a swept clear
module sales_ledger #(
  parameter int SELL_MAX = 31,
  parameter int TURN_MAX = 99
) (
  input  logic clk,
  input  logic rst,
  sales_ledger_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COMMIT, CLEAR} state_t;

  localparam logic [7:0] SELL_MAX8 = 8'(SELL_MAX);
  localparam logic [7:0] TURN_MAX8 = 8'(TURN_MAX);

  state_t     state, state_nx;
  logic [4:0] sell_r [1:7];
  logic [6:0] turn_r;
  logic       sat_r;
  logic       done_r;
  logic       err_r;
  logic       clr_pend;
  logic [2:0] idx;
  logic [2:0] item_q;
  logic [1:0] qty_q;
  logic [6:0] amt_q;

  logic       ready;
  logic       accept;
  logic       start_clr;
  logic       bad_sale;
  logic [4:0] cur_sell;
  logic [7:0] sell_sum;
  logic [7:0] turn_sum;
  logic [4:0] sell_new;
  logic [6:0] turn_new;
  logic       clamp;

  // A pending or fresh clear blocks acceptance so the sweep always wins the IDLE slot.
  assign ready = (state == IDLE) & ~rst & ~bus.clr_req & ~clr_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    start_clr = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clr_req | clr_pend) begin
          state_nx  = CLEAR;
          start_clr = 1'b1;
        end else if (bus.sale_valid & ready) begin
          state_nx = COMMIT;
          accept   = 1'b1;
        end
      end
      COMMIT:  state_nx = IDLE;
      CLEAR:   if (idx == 3'd7) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cur_sell = '0;
    for (int i = 1; i <= 7; i++)
      if (item_q == 3'(i)) cur_sell = sell_r[i];
    bad_sale = (item_q == 3'd0) | (qty_q == 2'd0);
    sell_sum = {3'b000, cur_sell} + {6'b000000, qty_q};
    turn_sum = {1'b0, turn_r} + {1'b0, amt_q};
    sell_new = (sell_sum > SELL_MAX8) ? SELL_MAX8[4:0] : sell_sum[4:0];
    turn_new = (turn_sum > TURN_MAX8) ? TURN_MAX8[6:0] : turn_sum[6:0];
    clamp    = (sell_sum > SELL_MAX8) | (turn_sum > TURN_MAX8);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= 7; i++) sell_r[i] <= '0;
      turn_r   <= '0;
      sat_r    <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      clr_pend <= 1'b0;
      idx      <= '0;
      item_q   <= '0;
      qty_q    <= '0;
      amt_q    <= '0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_clr) begin
            idx      <= 3'd1;
            clr_pend <= 1'b0;
          end else if (accept) begin
            item_q <= bus.sale_item;
            qty_q  <= bus.sale_qty;
            amt_q  <= bus.sale_amount;
          end
        end
        COMMIT: begin
          if (bus.clr_req) clr_pend <= 1'b1;
          if (bad_sale) begin
            err_r <= 1'b1;
          end else begin
            for (int i = 1; i <= 7; i++)
              if (item_q == 3'(i)) sell_r[i] <= sell_new;
            turn_r <= turn_new;
            if (clamp) sat_r <= 1'b1;
            done_r <= 1'b1;
          end
        end
        CLEAR: begin
          // Requests during the sweep are absorbed: clr_pend is never set here.
          for (int i = 1; i <= 7; i++)
            if (idx == 3'(i)) sell_r[i] <= '0;
          if (idx == 3'd1) begin
            turn_r <= '0;
            sat_r  <= 1'b0;
          end
          idx <= idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.sale_ready = ready;
  assign bus.clr_busy   = (state == CLEAR);
  assign bus.sale_done  = done_r;
  assign bus.sale_err   = err_r;
  assign bus.sat_flag   = sat_r;
  assign bus.turnover   = turn_r;
  assign bus.sell1      = sell_r[1];
  assign bus.sell2      = sell_r[2];
  assign bus.sell3      = sell_r[3];
  assign bus.sell4      = sell_r[4];
  assign bus.sell5      = sell_r[5];
  assign bus.sell6      = sell_r[6];
  assign bus.sell7      = sell_r[7];

endmodule
